// File: rtl/memio_bridge_pkg.sv
// Shared definitions for the CPU memory/IO bridge: access sizes, IO FSM
// states, default IO window and the fixed device slot assignments.
package memio_bridge_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } io_state_e;

  localparam logic [23:0] IO_BASE_DEFAULT = 24'hFFFFFC;

  // Device slots inside the IO window (caddress[7:4])
  localparam int unsigned DEV_TUBE     = 0;
  localparam int unsigned DEV_KEYBOARD = 1;
  localparam int unsigned DEV_TIMER    = 2;
  localparam int unsigned DEV_PWM      = 3;
  localparam int unsigned DEV_WATCHDOG = 5;
  localparam int unsigned DEV_LED      = 6;
  localparam int unsigned DEV_SWITCH   = 7;

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/memio_lane.sv
// Byte-lane helper: write byte enables, store-data replication and
// sub-word read extraction with optional sign extension.
module memio_lane
  import memio_bridge_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wrep,
  output logic [31:0] rext,
  output logic        misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte      = rword[{offset, 3'b000} +: 8];
  assign rhalf      = rword[{offset[1], 4'b0000} +: 16];
  assign misaligned = is_misaligned(size, offset);

  // Per-size lane selection for both write and read directions
  always_comb begin
    byte_en = '0;
    wrep    = '0;
    rext    = '0;
    case (size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << offset;
        wrep    = {4{wdata[7:0]}};
        rext    = {{24{sign_ext & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        byte_en = 4'b0011 << offset;
        wrep    = {2{wdata[15:0]}};
        rext    = {{16{sign_ext & rhalf[15]}}, rhalf};
      end
      SZ_WORD: begin
        byte_en = 4'b1111;
        wrep    = wdata;
        rext    = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memio_bridge.sv
// Memory/IO bridge between the CPU datapath and data memory plus a small
// window of memory-mapped IO devices. Memory accesses are combinational;
// IO accesses run through a stalling handshake FSM with a bus timeout.
module memio_bridge
  import memio_bridge_pkg::*;
#(
  parameter int unsigned N_DEV    = 8,
  parameter logic [23:0] IO_BASE  = IO_BASE_DEFAULT,
  parameter int unsigned MIN_WAIT = 1,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      caddress,
  input  logic             memread,
  input  logic             memwrite,
  input  logic             ioread,
  input  logic             iowrite,
  input  logic [1:0]       size,
  input  logic             sign_ext,
  input  logic [31:0]      wdata,
  input  logic [31:0]      mread_data,
  input  logic [15:0]      ioread_data,
  input  logic             io_ready,
  output logic [31:0]      rdata,
  output logic [31:0]      write_data,
  output logic [31:0]      address,
  output logic [3:0]       byte_en,
  output logic [N_DEV-1:0] cs,
  output logic             io_rd,
  output logic             io_wr,
  output logic             stall,
  output logic             bus_err,
  output logic             align_err
);

  localparam int unsigned CW = (TIMEOUT > 15) ? $clog2(TIMEOUT + 1) : 4;

  io_state_e        state;
  logic [CW-1:0]    wait_cnt;
  logic [CW-1:0]    wait_nxt;
  logic [N_DEV-1:0] cs_q;
  logic [N_DEV-1:0] dev_sel;
  logic             io_rd_q, io_wr_q, bus_err_q;
  logic             wr_q, timeout_q, sign_q;
  size_e            size_q;
  logic [31:0]      wdata_q;
  logic [15:0]      rd_q;

  logic             io_req, mem_req, wr_req, in_window, dev_ok, idle, busy;
  logic             start_hit, start_miss, ready_ok, timed_out;

  logic [3:0]       mem_be;
  logic [31:0]      mem_wrep, mem_rext;
  logic             mis;
  logic [31:0]      io_wrep, io_rext;
  // Outputs not needed on the IO read path
  logic [3:0]       io_be_unused;
  logic             io_mis_unused;

  memio_lane u_mem_lane (
    .size       (size_e'(size)),
    .offset     (caddress[1:0]),
    .sign_ext   (sign_ext),
    .wdata      (wdata),
    .rword      (mread_data),
    .byte_en    (mem_be),
    .wrep       (mem_wrep),
    .rext       (mem_rext),
    .misaligned (mis)
  );

  // Device data is 16 bits wide and always sits in the low lanes
  memio_lane u_io_lane (
    .size       (size_q),
    .offset     (2'b00),
    .sign_ext   (sign_q),
    .wdata      (wdata_q),
    .rword      ({16'h0000, rd_q}),
    .byte_en    (io_be_unused),
    .wrep       (io_wrep),
    .rext       (io_rext),
    .misaligned (io_mis_unused)
  );

  assign address    = caddress;
  assign io_req     = ioread | iowrite;
  assign mem_req    = memread | memwrite;
  assign wr_req     = memwrite | iowrite;
  assign in_window  = caddress[31:8] == IO_BASE;
  assign dev_ok     = {1'b0, caddress[7:4]} < 5'(N_DEV);
  assign idle       = state == ST_IDLE;
  assign busy       = (state == ST_ACCESS) || (state == ST_WAIT);
  assign start_hit  = ~reset & idle & io_req & ~mis & in_window & dev_ok;
  assign start_miss = ~reset & idle & io_req & ~mis & ~(in_window & dev_ok);
  assign wait_nxt   = wait_cnt + CW'(1);
  assign ready_ok   = io_ready && (wait_nxt >= CW'(MIN_WAIT));
  assign timed_out  = wait_nxt == CW'(TIMEOUT);

  assign stall      = ~reset & (start_hit | start_miss | busy);
  assign align_err  = ~reset & idle & (io_req | mem_req) & mis;
  assign cs         = cs_q;
  assign io_rd      = io_rd_q;
  assign io_wr      = io_wr_q;
  assign bus_err    = bus_err_q;

  // IO requests take the byte enables; a memory write beside an IO read is dropped
  assign byte_en    = (~mis & (iowrite | (memwrite & ~ioread))) ? mem_be : '0;

  // One-hot decode of the device slot
  always_comb begin
    dev_sel = '0;
    for (int unsigned i = 0; i < N_DEV; i++) dev_sel[i] = (caddress[7:4] == 4'(i));
  end

  // Store data: latched copy while a device write is in flight
  always_comb begin
    if (busy && wr_q)  write_data = io_wrep;
    else if (wr_req)   write_data = mem_wrep;
    else               write_data = '0;
  end

  // Write-back data: IO result in DONE, memory lane otherwise
  always_comb begin
    if (state == ST_DONE)   rdata = (~wr_q & ~timeout_q) ? io_rext : '0;
    else if (io_req | mis)  rdata = '0;
    else                    rdata = mem_rext;
  end

  // IO handshake FSM; reset mid-access simply abandons the transfer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      cs_q      <= '0;
      io_rd_q   <= 1'b0;
      io_wr_q   <= 1'b0;
      bus_err_q <= 1'b0;
      wr_q      <= 1'b0;
      timeout_q <= 1'b0;
      sign_q    <= 1'b0;
      size_q    <= SZ_BYTE;
      wdata_q   <= '0;
      rd_q      <= '0;
    end else begin
      io_rd_q   <= 1'b0;
      io_wr_q   <= 1'b0;
      bus_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_hit) begin
            state     <= ST_ACCESS;
            cs_q      <= dev_sel;
            io_rd_q   <= ~iowrite;
            io_wr_q   <= iowrite;
            wr_q      <= iowrite;
            timeout_q <= 1'b0;
            size_q    <= size_e'(size);
            sign_q    <= sign_ext;
            wdata_q   <= wdata;
          end else if (start_miss) begin
            // Unmapped target: skip the handshake and report straight away
            state     <= ST_DONE;
            wr_q      <= iowrite;
            timeout_q <= 1'b1;
            bus_err_q <= 1'b1;
          end
        end
        ST_ACCESS: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt <= wait_nxt;
          if (ready_ok || timed_out) begin
            state     <= ST_DONE;
            cs_q      <= '0;
            timeout_q <= ~ready_ok;
            bus_err_q <= ~ready_ok;
            rd_q      <= ioread_data;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memio_bridge.sv
// Scoreboard bench for memio_bridge: a driver issues transactions and
// queues the expected response from a behavioural model; a monitor pops
// and compares whenever the bridge completes an access (request, no stall).
module tb_memio_bridge;

  localparam int unsigned N_DEV    = 8;
  localparam int unsigned MIN_WAIT = 1;
  localparam int unsigned TIMEOUT  = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] caddress, wdata, mread_data;
  logic        memread, memwrite, ioread, iowrite, sign_ext, io_ready;
  logic [1:0]  size;
  logic [15:0] ioread_data;
  logic [31:0] rdata, write_data, address;
  logic [3:0]  byte_en;
  logic [7:0]  cs;
  logic        io_rd, io_wr, stall, bus_err, align_err;

  memio_bridge #(
    .N_DEV    (N_DEV),
    .IO_BASE  (24'hFFFFFC),
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .caddress    (caddress),
    .memread     (memread),
    .memwrite    (memwrite),
    .ioread      (ioread),
    .iowrite     (iowrite),
    .size        (size),
    .sign_ext    (sign_ext),
    .wdata       (wdata),
    .mread_data  (mread_data),
    .ioread_data (ioread_data),
    .io_ready    (io_ready),
    .rdata       (rdata),
    .write_data  (write_data),
    .address     (address),
    .byte_en     (byte_en),
    .cs          (cs),
    .io_rd       (io_rd),
    .io_wr       (io_wr),
    .stall       (stall),
    .bus_err     (bus_err),
    .align_err   (align_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] addr;
    bit          mr, mw, ir, iw;
    logic [1:0]  sz;
    bit          sx;
    logic [31:0] wd, md;
    logic [15:0] iod;
    int unsigned rdy;   // wait cycle at which the device answers, 0 = never
  } txn_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    bit          chk_rd;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          chk_wd;
    logic [7:0]  cs;
    int unsigned stall, nrd, nwr;
    bit          berr, aerr;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cur_rdy = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] extend(input logic [31:0] w, input int unsigned off,
                                         input logic [1:0] sz, input bit sx);
    logic [31:0] v;
    v = w >> (8 * off);
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic exp_t model(input txn_t t);
    exp_t        e;
    int unsigned off, idx, wcyc;
    bit          mis, hit, done;
    off  = t.addr % 4;
    idx  = (t.addr >> 4) % 16;
    e.name = t.name; e.rdata = 0; e.chk_rd = 0; e.cs = 0;
    e.stall = 0; e.nrd = 0; e.nwr = 0; e.berr = 0; e.aerr = 0;
    mis = (t.sz == 3) || (t.sz == 1 && off % 2 != 0) || (t.sz == 2 && off != 0);
    e.chk_wd = (t.sz != 3);
    e.wd = 0;
    if (t.mw || t.iw)
      e.wd = (t.sz == 0) ? t.wd[7:0] * 32'h01010101 :
             (t.sz == 1) ? t.wd[15:0] * 32'h00010001 : t.wd;
    e.be = 0;
    if (!mis && (t.iw || (t.mw && !t.ir)))
      e.be = (t.sz == 0) ? 4'(1 << off) : (t.sz == 1) ? 4'(3 << off) : 4'hF;
    if (mis) begin
      e.aerr = 1; e.chk_rd = 1;
    end else if (t.ir || t.iw) begin
      hit = ((t.addr >> 8) == 32'h00FFFFFC) && (idx < N_DEV);
      if (!hit) begin
        e.stall = 1; e.berr = 1; e.chk_rd = 1;
      end else begin
        e.cs = 8'(1 << idx);
        if (t.iw) e.nwr = 1; else e.nrd = 1;
        done = 0; wcyc = TIMEOUT;
        for (int unsigned k = 1; k <= TIMEOUT; k++) begin
          wcyc = k;
          if (t.rdy != 0 && k >= t.rdy && k >= MIN_WAIT) begin done = 1; break; end
        end
        e.stall  = 2 + wcyc;
        e.berr   = !done;
        e.chk_rd = t.ir;
        if (done && t.ir && !t.iw) e.rdata = extend({16'h0, t.iod}, 0, t.sz, t.sx);
      end
    end else if (t.mr) begin
      e.chk_rd = 1;
      e.rdata  = extend(t.md, off, t.sz, t.sx);
    end
    return e;
  endfunction

  function automatic txn_t mk(input string nm, input logic [31:0] a, input bit mr, input bit mw,
                              input bit ir, input bit iw, input logic [1:0] sz, input bit sx,
                              input logic [31:0] wd, input logic [31:0] md,
                              input logic [15:0] iod, input int unsigned rdy);
    txn_t t;
    t.name = nm; t.addr = a; t.mr = mr; t.mw = mw; t.ir = ir; t.iw = iw;
    t.sz = sz; t.sx = sx; t.wd = wd; t.md = md; t.iod = iod; t.rdy = rdy;
    return t;
  endfunction

  function automatic txn_t rand_txn(input int n);
    txn_t        t;
    logic [31:0] r;
    int unsigned k;
    r = $urandom();
    t = mk($sformatf("rnd%0d", n), r, 0, 0, 0, 0, 2'($urandom_range(0, 2)),
           1'($urandom_range(0, 1)), $urandom(), $urandom(), 16'($urandom()),
           $urandom_range(1, 5));
    if ($urandom_range(0, 7) == 0) t.rdy = 0;
    k = (t.sz == 0) ? $urandom_range(0, 3) : (t.sz == 1) ? 2 * $urandom_range(0, 1) : 0;
    t.addr[1:0] = 2'(k);
    case ($urandom_range(0, 6))
      0: t.mr = 1;
      1: t.mw = 1;
      2, 3: begin
        if ($urandom_range(0, 1) == 1) t.ir = 1; else t.iw = 1;
        t.addr[31:8] = 24'hFFFFFC;
        t.addr[7:4]  = 4'($urandom_range(0, N_DEV - 1));
      end
      4: begin
        if ($urandom_range(0, 1) == 1) t.ir = 1; else t.iw = 1;
        t.addr[31:8] = 24'hFFFFFC;
        t.addr[7:4]  = 4'($urandom_range(N_DEV, 15));
        if ($urandom_range(0, 1) == 1) t.addr[31:8] = 24'h001234;
      end
      5: begin
        case ($urandom_range(0, 2))
          0: t.mr = 1;
          1: t.mw = 1;
          default: t.ir = 1;
        endcase
        t.sz = 2'($urandom_range(1, 3));
        if (t.sz == 1)      t.addr[1:0] = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'd3;
        else if (t.sz == 2) t.addr[1:0] = 2'($urandom_range(1, 3));
      end
      default: begin
        if ($urandom_range(0, 1) == 1) t.mr = 1; else t.mw = 1;
        t.ir = 1;
        t.addr[31:8] = 24'hFFFFFC;
        t.addr[7:4]  = 4'($urandom_range(0, N_DEV - 1));
      end
    endcase
    return t;
  endfunction

  task automatic idle_cycle();
    memread = 0; memwrite = 0; ioread = 0; iowrite = 0;
    @(posedge clock); #1;
  endtask

  task automatic apply(input txn_t t);
    bit done;
    exp_q.push_back(model(t));
    caddress = t.addr; memread = t.mr; memwrite = t.mw; ioread = t.ir; iowrite = t.iw;
    size = t.sz; sign_ext = t.sx; wdata = t.wd; mread_data = t.md;
    ioread_data = t.iod; cur_rdy = t.rdy;
    done = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clock);
      if (!stall) begin done = 1; break; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s.complete actual=stalled required=done", t.name);
      exp_q.delete(exp_q.size() - 1);
    end
    @(posedge clock); #1;
  endtask

  // Device model: answers io_ready from the chosen wait cycle onward
  initial begin
    int unsigned k;
    io_ready = 0;
    forever begin
      @(negedge clock);
      if (!reset && (io_rd || io_wr)) begin
        k = 0;
        for (int g = 0; g < 40; g++) begin
          @(posedge clock); #1;
          k++;
          if (cs == 0 || reset) break;
          io_ready = (cur_rdy != 0 && k >= cur_rdy);
        end
        io_ready = 0;
      end
    end
  end

  // Monitor: accumulate per-access activity, compare on completion
  initial begin
    int unsigned st, nrd, nwr;
    logic [7:0]  cso;
    exp_t        e;
    st = 0; nrd = 0; nwr = 0; cso = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        st = 0; nrd = 0; nwr = 0; cso = 0;
      end else begin
        st += stall; nrd += io_rd; nwr += io_wr; cso |= cs;
        if ((memread || memwrite || ioread || iowrite) && !stall) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_completion actual=response required=none");
          end else begin
            e = exp_q.pop_front();
            if (e.chk_rd) chk({e.name, ".rdata"}, rdata, e.rdata);
            if (e.chk_wd) chk({e.name, ".write_data"}, write_data, e.wd);
            chk({e.name, ".byte_en"},   32'(byte_en),   32'(e.be));
            chk({e.name, ".cs"},        32'(cso),       32'(e.cs));
            chk({e.name, ".stall"},     st,             e.stall);
            chk({e.name, ".io_rd"},     nrd,            e.nrd);
            chk({e.name, ".io_wr"},     nwr,            e.nwr);
            chk({e.name, ".bus_err"},   32'(bus_err),   32'(e.berr));
            chk({e.name, ".align_err"}, 32'(align_err), 32'(e.aerr));
          end
          st = 0; nrd = 0; nwr = 0; cso = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    reset = 1;
    caddress = 32'h102; memread = 1; memwrite = 0; ioread = 0; iowrite = 0;
    size = 2'd1; sign_ext = 1; wdata = 0; mread_data = 32'h80010000; ioread_data = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst.cs", 32'(cs), 0);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.io_rd", 32'(io_rd), 0);
    chk("rst.io_wr", 32'(io_wr), 0);
    chk("rst.bus_err", 32'(bus_err), 0);
    chk("rst.align_err", 32'(align_err), 0);
    chk("rst.address", address, 32'h102);
    chk("rst.rdata", rdata, extend(32'h80010000, 2, 2'd1, 1));
    memread = 0;
    @(posedge clock); #1;
    reset = 0;
    idle_cycle();

    apply(mk("sw_word",   32'h104, 0, 1, 0, 0, 2'd2, 0, 32'hA1B2C3D4, 0, 0, 0));
    apply(mk("lb_sx",     32'h103, 1, 0, 0, 0, 2'd0, 1, 0, 32'h80FF7F01, 0, 0));
    apply(mk("lbu",       32'h103, 1, 0, 0, 0, 2'd0, 0, 0, 32'h80FF7F01, 0, 0));
    apply(mk("io_rd_d7",  32'hFFFFFC70, 0, 0, 1, 0, 2'd2, 0, 0, 0, 16'h1234, 1));
    apply(mk("io_wr_to",  32'hFFFFFC60, 0, 0, 0, 1, 2'd2, 0, 32'h55AA1234, 0, 0, 0));
    apply(mk("sh_mis",    32'h101, 0, 1, 0, 0, 2'd1, 0, 32'hCAFEBEEF, 0, 0, 0));
    apply(mk("io_miss",   32'hFFFFFCF0, 0, 0, 1, 0, 2'd2, 0, 0, 0, 16'hBEEF, 1));
    apply(mk("io_lh_sx",  32'hFFFFFC12, 0, 0, 1, 0, 2'd1, 1, 0, 0, 16'h8001, 3));
    apply(mk("io_lbu",    32'hFFFFFC03, 0, 0, 1, 0, 2'd0, 0, 0, 0, 16'h80F0, 2));
    apply(mk("mw_io_rd",  32'hFFFFFC50, 0, 1, 1, 0, 2'd2, 0, 32'h0BADF00D, 0, 16'h00C3, 2));
    apply(mk("sb_lane2",  32'h00000206, 0, 1, 0, 0, 2'd0, 0, 32'h000000E7, 0, 0, 0));
    idle_cycle();

    for (int n = 0; n < 80; n++) begin
      apply(rand_txn(n));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    // Reset while the FSM sits in WAIT
    caddress = 32'hFFFFFC20; ioread = 1; size = 2'd2; sign_ext = 0; cur_rdy = 0;
    repeat (3) @(posedge clock);
    #2;
    chk("rstwait.cs_before", 32'(cs), 32'h04);
    reset = 1;
    #1;
    chk("rstwait.cs", 32'(cs), 0);
    chk("rstwait.stall", 32'(stall), 0);
    chk("rstwait.io_rd", 32'(io_rd), 0);
    chk("rstwait.io_wr", 32'(io_wr), 0);
    ioread = 0;
    @(posedge clock); #1;
    reset = 0;
    idle_cycle();
    apply(mk("post_rst_rd", 32'hFFFFFC20, 0, 0, 1, 0, 2'd2, 0, 0, 0, 16'h7E57, 2));
    idle_cycle();
    idle_cycle();

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memio_bridge.md
MEMIO_BRIDGE -- requirements
Module: memio_bridge

Interface
REQ-001 Parameters (name, default, meaning): N_DEV, 8, number of IO devices (1..16); IO_BASE, 24'hFFFFFC, caddress[31:8] value selecting the IO window; MIN_WAIT, 1, minimum wait cycles per IO access; TIMEOUT, 15, maximum wait cycles before bus error (TIMEOUT > MIN_WAIT).
REQ-002 Ports (name, direction, width, meaning): clock in 1 system clock; reset in 1 asynchronous active-high reset.
REQ-003 caddress in 32 byte address from ALU; memread in 1; memwrite in 1; ioread in 1; iowrite in 1 (all from control32).
REQ-004 size in 2 access size (00 byte, 01 half, 10 word, 11 reserved); sign_ext in 1 sign-extend sub-word reads.
REQ-005 wdata in 32 store data from decoder; mread_data in 32 memory read word; ioread_data in 16 selected device read data; io_ready in 1 selected device done.
REQ-006 rdata out 32 register write-back data; write_data out 32 lane-replicated store data; address out 32 pass-through caddress; byte_en out 4 write byte enables.
REQ-007 cs out N_DEV one-hot device select; io_rd out 1 and io_wr out 1 single-cycle device strobes; stall out 1 pipeline hold; bus_err out 1 and align_err out 1 one-cycle error pulses.

Function
REQ-008 address SHALL equal caddress combinationally.
REQ-009 Memory path SHALL be combinational, zero stall: rdata = lane of mread_data selected by caddress[1:0] and size, sign- or zero-extended per sign_ext.
REQ-010 Misalignment (half with caddress[0]=1, word with caddress[1:0]!=0, size=11) SHALL suppress the access (byte_en=0, no cs, no strobe), pulse align_err one cycle, rdata=0.
REQ-011 byte_en SHALL be 0001<<a for byte, 0011<<a for half, 1111 for word, only while memwrite or iowrite; else 0000.
REQ-012 write_data SHALL be {4{wdata[7:0]}} byte, {2{wdata[15:0]}} half, wdata word, while a write is requested; else 32'h0 (never high-impedance).
REQ-013 IO hit: (ioread|iowrite) and caddress[31:8]==IO_BASE and caddress[7:4]<N_DEV; device index = caddress[7:4].
REQ-014 IO FSM states IDLE, ACCESS, WAIT, DONE; wait counter 4 bits minimum.
REQ-015 IDLE: on aligned IO request, register caddress, write_data, index, direction; go ACCESS; stall asserted combinationally in that same cycle.
REQ-016 ACCESS (1 cycle): cs[index]=1, io_rd or io_wr=1, counter cleared; go WAIT.
REQ-017 WAIT: cs held, strobes low, counter increments; go DONE when io_ready=1 and counter>=MIN_WAIT, or when counter==TIMEOUT (bus_err pulses in DONE).
REQ-018 DONE (1 cycle): stall=0, cs=0; rdata = latched ioread_data zero-extended (sign-extended from bit 7/15 per size and sign_ext) or 0 on timeout; go IDLE.
REQ-019 Latency: IO access completes no earlier than 3+MIN_WAIT cycles after request; stall high for exactly those cycles minus one.
REQ-020 IO miss (window match, index>=N_DEV; or ioread/iowrite outside window): no cs, no strobe, stall one cycle, then bus_err pulse, rdata=0.
REQ-021 memread/memwrite together with ioread/iowrite: IO request wins; memory byte_en forced 0.
REQ-022 Requests arriving while FSM not IDLE SHALL be ignored (CPU held by stall).

Reset
REQ-023 reset SHALL asynchronously force IDLE, counter 0, latches 0, cs=0, io_rd=io_wr=0, stall=0, bus_err=align_err=0; mid-access reset aborts without completing.
REQ-024 Combinational outputs (address, byte_en, write_data, memory rdata) follow inputs during reset.

Structure
REQ-025 Shared package: size encodings, FSM state enum, IO_BASE default, device index constants (digital tube 0, keyboard 1, timer 2, PWM 3, watchdog 5, LED 6, switch 7).
REQ-026 One sub-module: memio_lane (byte_en generation, write replication, read extract/extend), instantiated for memory and IO read paths.

Verification
REQ-027 sw caddress=0x104, wdata=0xA1B2C3D4 -> byte_en=1111, write_data=0xA1B2C3D4, stall=0, no cs.
REQ-028 lb caddress=0x103, mread_data=0x80FF7F01, sign_ext=1 -> rdata=0xFFFFFF80; sign_ext=0 -> 0x00000080.
REQ-029 ioread caddress=0xFFFFFC70, io_ready=1 at WAIT cycle 1, ioread_data=0x1234 -> cs=0x80, io_rd one cycle, rdata=0x00001234 in DONE, stall high 3 cycles.
REQ-030 iowrite caddress=0xFFFFFC60, io_ready never -> bus_err after TIMEOUT=15 wait cycles, rdata=0, FSM IDLE next cycle.
REQ-031 sh caddress=0x101 -> align_err one cycle, byte_en=0000; ioread caddress=0xFFFFFCF0 with N_DEV=8 -> no cs, bus_err.
REQ-032 reset asserted in WAIT -> cs, stall, strobes 0 immediately; next request after release completes normally.
